// File: rtl/clock_domain_reset_sequencer.sv
// Power-on and soft reset sequencer for a set of clock domains.
// After power-on every domain is held in reset for STRETCH_CYCLES, then the
// domains are released one at a time, STAGGER_CYCLES apart, in ascending
// index order. Once all domains run, a masked soft reset can be requested;
// the selected domains are held for STRETCH_CYCLES and released together.
// All outputs come straight from flops, so they cannot glitch.
module clock_domain_reset_sequencer #(
    parameter int NUM_DOMAINS    = 5,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [NUM_DOMAINS-1:0] req_mask,
    output logic                   req_ready,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_released,
    output logic                   req_done
);

    // Both delays are at most 255, so an 8-bit counter reaching value-1
    // never wraps.
    localparam int          CNT_W        = 8;
    localparam int          IDX_W        = $clog2(NUM_DOMAINS + 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN,
        SOFT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic [NUM_DOMAINS-1:0] mask_q, mask_d;
    logic                   ready_q, ready_d;
    logic                   rel_q, rel_d;
    logic                   done_q, done_d;

    // Next-state and next-output logic; every output is computed here and
    // registered below.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        mask_d  = mask_q;
        ready_d = ready_q;
        rel_d   = rel_q;
        done_d  = 1'b0;

        case (state_q)
            HOLD: begin
                rst_d = '1;
                if (cnt_q == STRETCH_LAST) begin
                    rst_d[0] = 1'b0;
                    cnt_d    = '0;
                    idx_d    = IDX_W'(1);
                    if (NUM_DOMAINS == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        rel_d   = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                if (cnt_q == STAGGER_LAST) begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        rel_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                if (req_valid && ready_q) begin
                    // The mask is captured here; later changes cannot
                    // affect the soft reset in progress.
                    mask_d  = req_mask;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SOFT;
                    if (req_mask != '0) begin
                        rst_d = req_mask;
                        rel_d = 1'b0;
                    end
                end
            end

            SOFT: begin
                // An empty mask completes on the very next edge.
                if ((mask_q == '0) || (cnt_q == STRETCH_LAST)) begin
                    rst_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    rel_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // Control state and output registers, forced to the held-in-reset
    // condition whenever reset is sampled low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            rel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    // Captured request mask; only read in SOFT, which reset always leaves.
    always_ff @(posedge clock) begin
        mask_q <= mask_d;
    end

    assign domain_reset = rst_q;
    assign req_ready    = ready_q;
    assign all_released = rel_q;
    assign req_done     = done_q;

endmodule

// File: tb/tb_clock_domain_reset_sequencer.sv
// Bench for clock_domain_reset_sequencer with default parameters.
// Expected output words {domain_reset, all_released, req_ready, req_done}
// are pushed to a queue before each edge and popped after it.
module tb_clock_domain_reset_sequencer;

    localparam int N = 5;
    localparam int S = 16;
    localparam int G = 4;
    localparam logic [7:0] HELD = 8'b11111_000;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic [N-1:0] req_mask;
    logic         req_ready;
    logic [N-1:0] domain_reset;
    logic         all_released;
    logic         req_done;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    clock_domain_reset_sequencer #(
        .NUM_DOMAINS   (N),
        .STRETCH_CYCLES(S),
        .STAGGER_CYCLES(G)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mask    (req_mask),
        .req_ready   (req_ready),
        .domain_reset(domain_reset),
        .all_released(all_released),
        .req_done    (req_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs j edges after reset was first sampled high.
    function automatic logic [7:0] exp_power(input int j);
        logic [N-1:0] dr;
        for (int i = 0; i < N; i++) dr[i] = (j < S + i * G);
        return {dr, (j >= S + (N - 1) * G), (j >= S + (N - 1) * G), 1'b0};
    endfunction

    // Expected outputs p edges after a soft request was accepted at edge T.
    function automatic logic [7:0] exp_soft(input logic [N-1:0] m, input int p);
        if (m != '0) begin
            if (p < S)  return {m, 3'b000};
            if (p == S) return {5'b00000, 3'b111};
            return {5'b00000, 3'b110};
        end
        if (p == 0) return {5'b00000, 3'b100};
        if (p == 1) return {5'b00000, 3'b111};
        return {5'b00000, 3'b110};
    endfunction

    task automatic test_reset();
        logic [7:0] got, want;
        reset = 1'b0; req_valid = 1'b1; req_mask = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(HELD);
            @(posedge clock); #1;
            got  = {domain_reset, all_released, req_ready, req_done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset k=%0d got=%b want=%b", k, got, want);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_power_on(input int abort_at, input bit poke);
        logic [7:0] got, want;
        int last, j;
        reset = 1'b0; req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(HELD);
            @(posedge clock); #1;
            got  = {domain_reset, all_released, req_ready, req_done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL power_pre k=%0d got=%b want=%b", k, got, want);
            end
        end
        last = (abort_at > 0) ? abort_at + 34 : 34;
        for (int k = 1; k <= last; k++) begin
            reset     = (k == abort_at) ? 1'b0 : 1'b1;
            req_valid = poke && (k == 22);
            req_mask  = 5'b11111;
            j = (abort_at > 0 && k > abort_at) ? k - abort_at : k;
            exp_q.push_back((k == abort_at) ? HELD : exp_power(j));
            @(posedge clock); #1;
            got  = {domain_reset, all_released, req_ready, req_done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL power_on abort=%0d poke=%0d k=%0d got=%b want=%b",
                         abort_at, poke, k, got, want);
            end
        end
        req_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_soft(input logic [N-1:0] m, input int abort_at);
        logic [7:0] got, want;
        int last;
        last = (abort_at > 0) ? abort_at + 34 : 20;
        for (int k = 0; k <= last; k++) begin
            reset     = (abort_at > 0 && k == abort_at) ? 1'b0 : 1'b1;
            req_valid = (k == 0) || (m != '0 && k >= 3 && k <= 10);
            req_mask  = (k == 0) ? m : 5'($urandom);
            if (abort_at > 0 && k == abort_at)     exp_q.push_back(HELD);
            else if (abort_at > 0 && k > abort_at) exp_q.push_back(exp_power(k - abort_at));
            else                                   exp_q.push_back(exp_soft(m, k));
            @(posedge clock); #1;
            got  = {domain_reset, all_released, req_ready, req_done};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL soft mask=%b abort=%0d k=%0d got=%b want=%b",
                         m, abort_at, k, got, want);
            end
        end
        req_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, want;
        int dones = 0;
        for (int k = 0; k <= 51; k++) begin
            reset     = 1'b1;
            req_valid = (k <= 50);
            req_mask  = 5'b11111;
            if (k == 51)              exp_q.push_back({5'b00000, 3'b110});
            else if ((k % 17) == 16)  exp_q.push_back({5'b00000, 3'b111});
            else                      exp_q.push_back(HELD);
            @(posedge clock); #1;
            got  = {domain_reset, all_released, req_ready, req_done};
            want = exp_q.pop_front();
            if (req_done === 1'b1) dones++;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back k=%0d got=%b want=%b", k, got, want);
            end
        end
        req_valid = 1'b0;
        total++;
        if (dones !== 3) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d want=3", dones);
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_mask = '0;
        test_reset();
        test_power_on(0, 1'b0);
        test_soft(5'b00110, 0);
        test_soft(5'b00000, 0);
        test_soft(5'b10001, 0);
        test_power_on(0, 1'b1);
        test_power_on(25, 1'b0);
        test_soft(5'b11111, 5);
        test_back_to_back();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL queue_empty got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
